// File: rtl/round_reset_ctrl_pkg.sv
// Shared types and constants for the round reset controller.
// Optional build macro used by the top module: BTN_EDGE_EN.
package round_reset_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PULSE     = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    localparam int DEF_NUM_PLAYERS  = 2;
    localparam int DEF_SCORE_W      = 3;
    localparam int DEF_WIN_SCORE    = 5;
    localparam int DEF_RESET_CYCLES = 4;

    // Index width with a floor of one bit, so a single player still gets a port.
    function automatic int pid_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/round_reset_ctrl_if.sv
// Player-input / playfield-output bundle of the round reset controller.
interface round_reset_ctrl_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 3,
    parameter int PID_W       = 1
);
    logic [NUM_PLAYERS-1:0]         btn;
    logic [NUM_PLAYERS-1:0]         goal_light;
    logic                           new_game;
    logic                           round_rst;
    logic                           win_valid;
    logic [PID_W-1:0]               win_id;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores;
    logic                           game_over;

    // Input conditioners / game host side
    modport master (
        output btn, goal_light, new_game,
        input  round_rst, win_valid, win_id, scores, game_over
    );

    // Controller side
    modport slave (
        input  btn, goal_light, new_game,
        output round_rst, win_valid, win_id, scores, game_over
    );
endinterface

// File: rtl/round_reset_ctrl_score_counter.sv
// Per-player saturating score counter with synchronous clear.
module round_reset_ctrl_score_counter #(
    parameter int SCORE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               clr,
    output logic [SCORE_W-1:0] count
);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Clear wins over increment; count sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   count <= '0;
        else if (clr) count <= '0;
        else if (inc) count <= sat_inc(count);
    end

endmodule

// File: rtl/round_reset_ctrl.sv
// Round controller: scoring detection, round-reset pulse, scores, game over.
// Optional build macro: BTN_EDGE_EN (score on button rising edge instead of level).
module round_reset_ctrl
    import round_reset_ctrl_pkg::*;
#(
    parameter int NUM_PLAYERS  = DEF_NUM_PLAYERS,
    parameter int SCORE_W      = DEF_SCORE_W,
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input logic               clk,
    input logic               reset,
    round_reset_ctrl_if.slave bus
);

    localparam int PID_W = pid_width(NUM_PLAYERS);
    localparam int CNT_W = pid_width(RESET_CYCLES);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   round_rst;
    logic                   win_valid;
    logic [PID_W-1:0]       win_id;
    logic                   game_over;
    logic [NUM_PLAYERS-1:0] btn_q;
    logic [NUM_PLAYERS-1:0] hit;
    logic                   any_hit;
    logic [PID_W-1:0]       win_idx;
    logic [SCORE_W-1:0]     cur_score;
    logic                   accept;
    logic                   win_now;

`ifdef BTN_EDGE_EN
    logic [NUM_PLAYERS-1:0] btn_d;

    // Previous button level, for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) btn_d <= '0;
        else        btn_d <= bus.btn;
    end

    assign btn_q = bus.btn & ~btn_d;
`else
    assign btn_q = bus.btn;
`endif

    assign hit = bus.goal_light & btn_q;

    // Lowest-index hitting player wins; other simultaneous hits are dropped.
    always_comb begin
        any_hit = 1'b0;
        win_idx = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit = 1'b1;
                win_idx = PID_W'(i);
            end
        end
    end

    assign cur_score = bus.scores[int'(win_idx) * SCORE_W +: SCORE_W];
    // new_game outranks a coincident hit.
    assign accept    = (state == IDLE) && any_hit && !bus.new_game;
    assign win_now   = (cur_score == SCORE_W'(WIN_SCORE - 1));

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
        round_reset_ctrl_score_counter #(.SCORE_W(SCORE_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (accept && (win_idx == PID_W'(g))),
            .clr   (bus.new_game),
            .count (bus.scores[g*SCORE_W +: SCORE_W])
        );
    end

    // Round FSM with registered strobe, pulse and game-over outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            round_rst <= 1'b0;
            win_valid <= 1'b0;
            win_id    <= '0;
            game_over <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        win_valid <= 1'b1;
                        win_id    <= win_idx;
                        round_rst <= 1'b1;
                        cnt       <= CNT_W'(RESET_CYCLES - 1);
                        if (win_now) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= PULSE;
                        end
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        round_rst <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAME_OVER: begin
                    if (bus.new_game) begin
                        state     <= IDLE;
                        game_over <= 1'b0;
                        round_rst <= 1'b0;
                        cnt       <= '0;
                    end else if (round_rst) begin
                        if (cnt == '0) round_rst <= 1'b0;
                        else           cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.round_rst = round_rst;
    assign bus.win_valid = win_valid;
    assign bus.win_id    = win_id;
    assign bus.game_over = game_over;

endmodule

// File: tb/tb_round_reset_ctrl.sv
// Directed self-checking bench for round_reset_ctrl (default parameters).
module tb_round_reset_ctrl;

    logic clk;
    logic reset;
    int   checks = 0;
    int   passes = 0;

    round_reset_ctrl_if #(.NUM_PLAYERS(2), .SCORE_W(3), .PID_W(1)) bus ();

    round_reset_ctrl #(
        .NUM_PLAYERS(2), .SCORE_W(3), .WIN_SCORE(5), .RESET_CYCLES(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count round_rst high cycles from the current negedge, bounded.
    task automatic wait_rst_low(output int hi);
        hi = 0;
        while (bus.round_rst === 1'b1 && hi < 20) begin
            hi++;
            @(negedge clk);
        end
    endtask

    task automatic clear_game();
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.btn = '0; bus.goal_light = '0; bus.new_game = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.round_rst !== 1'b0) $display("FAIL rst_round_rst got %b want 0", bus.round_rst); else passes++;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (bus.round_rst !== 1'b0) $display("FAIL idle_round_rst got %b want 0", bus.round_rst); else passes++;
        checks++; if (bus.win_valid !== 1'b0) $display("FAIL idle_win_valid got %b want 0", bus.win_valid); else passes++;
        checks++; if (bus.win_id !== 1'b0) $display("FAIL idle_win_id got %b want 0", bus.win_id); else passes++;
        checks++; if (bus.game_over !== 1'b0) $display("FAIL idle_game_over got %b want 0", bus.game_over); else passes++;
        checks++; if (bus.scores !== 6'd0) $display("FAIL idle_scores got %b want 000000", bus.scores); else passes++;
    endtask

    task automatic test_single_hit();
        int hi;
        bus.goal_light = 2'b10; bus.btn = 2'b10;
        @(negedge clk);
        bus.goal_light = 2'b00; bus.btn = 2'b00;
        checks++; if (bus.win_valid !== 1'b1) $display("FAIL single_win_valid got %b want 1", bus.win_valid); else passes++;
        checks++; if (bus.win_id !== 1'b1) $display("FAIL single_win_id got %b want 1", bus.win_id); else passes++;
        checks++; if (bus.scores !== 6'b001_000) $display("FAIL single_scores got %b want 001000", bus.scores); else passes++;
        wait_rst_low(hi);
        checks++; if (hi != 4) $display("FAIL single_pulse_len got %0d want 4", hi); else passes++;
        checks++; if (bus.win_valid !== 1'b0) $display("FAIL single_strobe_len got %b want 0", bus.win_valid); else passes++;
        clear_game();
        checks++; if (bus.scores !== 6'd0) $display("FAIL single_clear got %b want 000000", bus.scores); else passes++;
    endtask

    task automatic test_simultaneous();
        int hi;
        int extra;
        bus.goal_light = 2'b11; bus.btn = 2'b11;
        @(negedge clk);
        bus.goal_light = 2'b00; bus.btn = 2'b00;
        checks++; if (bus.win_id !== 1'b0) $display("FAIL simul_win_id got %b want 0", bus.win_id); else passes++;
        checks++; if (bus.scores !== 6'b000_001) $display("FAIL simul_scores got %b want 000001", bus.scores); else passes++;
        // Player 1 hits while the pulse is running.
        extra = 0;
        bus.goal_light = 2'b10; bus.btn = 2'b10;
        repeat (2) begin
            @(negedge clk);
            if (bus.win_valid === 1'b1) extra++;
        end
        bus.goal_light = 2'b00; bus.btn = 2'b00;
        wait_rst_low(hi);
        checks++; if (extra != 0) $display("FAIL holdoff_strobes got %0d want 0", extra); else passes++;
        checks++; if (bus.scores !== 6'b000_001) $display("FAIL holdoff_scores got %b want 000001", bus.scores); else passes++;
        clear_game();
    endtask

    task automatic test_hit_vs_new_game();
        bus.goal_light = 2'b01; bus.btn = 2'b01; bus.new_game = 1'b1;
        @(negedge clk);
        bus.goal_light = 2'b00; bus.btn = 2'b00; bus.new_game = 1'b0;
        checks++; if (bus.win_valid !== 1'b0) $display("FAIL newgame_prio_valid got %b want 0", bus.win_valid); else passes++;
        checks++; if (bus.round_rst !== 1'b0) $display("FAIL newgame_prio_rst got %b want 0", bus.round_rst); else passes++;
        checks++; if (bus.scores !== 6'd0) $display("FAIL newgame_prio_scores got %b want 000000", bus.scores); else passes++;
    endtask

    task automatic test_game_over();
        int hi;
        for (int k = 1; k <= 5; k++) begin
            bus.goal_light = 2'b01; bus.btn = 2'b01;
            @(negedge clk);
            bus.goal_light = 2'b00; bus.btn = 2'b00;
            checks++; if (bus.win_valid !== 1'b1) $display("FAIL go_win_valid_%0d got %b want 1", k, bus.win_valid); else passes++;
            checks++; if (bus.scores !== {3'd0, 3'(k)}) $display("FAIL go_score_%0d got %b want %b", k, bus.scores, {3'd0, 3'(k)}); else passes++;
            checks++; if (bus.game_over !== (k == 5)) $display("FAIL go_flag_%0d got %b want %b", k, bus.game_over, (k == 5)); else passes++;
            wait_rst_low(hi);
            checks++; if (hi != 4) $display("FAIL go_pulse_len_%0d got %0d want 4", k, hi); else passes++;
        end
        bus.goal_light = 2'b11; bus.btn = 2'b11;
        repeat (3) @(negedge clk);
        bus.goal_light = 2'b00; bus.btn = 2'b00;
        checks++; if (bus.scores !== 6'b000_101) $display("FAIL go_frozen_scores got %b want 000101", bus.scores); else passes++;
        checks++; if (bus.round_rst !== 1'b0) $display("FAIL go_frozen_rst got %b want 0", bus.round_rst); else passes++;
        checks++; if (bus.game_over !== 1'b1) $display("FAIL go_held got %b want 1", bus.game_over); else passes++;
        clear_game();
        checks++; if (bus.game_over !== 1'b0) $display("FAIL go_newgame_flag got %b want 0", bus.game_over); else passes++;
        checks++; if (bus.scores !== 6'd0) $display("FAIL go_newgame_scores got %b want 000000", bus.scores); else passes++;
        bus.goal_light = 2'b10; bus.btn = 2'b10;
        @(negedge clk);
        bus.goal_light = 2'b00; bus.btn = 2'b00;
        checks++; if (bus.win_valid !== 1'b1 || bus.win_id !== 1'b1) $display("FAIL go_idle_again got valid=%b id=%b want 1/1", bus.win_valid, bus.win_id); else passes++;
        wait_rst_low(hi);
        clear_game();
    endtask

    task automatic test_hold();
        int hi;
        int n;
        int want_n;
`ifdef BTN_EDGE_EN
        want_n = 1;
`else
        want_n = 2;
`endif
        n = 0;
        bus.goal_light = 2'b01; bus.btn = 2'b01;
        repeat (8) begin
            @(negedge clk);
            if (bus.win_valid === 1'b1) n++;
        end
        bus.goal_light = 2'b00; bus.btn = 2'b00;
        checks++; if (n != want_n) $display("FAIL hold_strobes got %0d want %0d", n, want_n); else passes++;
        checks++; if (bus.scores !== {3'd0, 3'(want_n)}) $display("FAIL hold_scores got %b want %b", bus.scores, {3'd0, 3'(want_n)}); else passes++;
        wait_rst_low(hi);
        clear_game();
    endtask

    task automatic test_async_reset();
        bus.goal_light = 2'b10; bus.btn = 2'b10;
        @(negedge clk);
        bus.goal_light = 2'b00; bus.btn = 2'b00;
        @(negedge clk);
        checks++; if (bus.round_rst !== 1'b1 || bus.scores !== 6'b001_000) $display("FAIL arst_pre got rst=%b scores=%b want 1/001000", bus.round_rst, bus.scores); else passes++;
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.round_rst !== 1'b0) $display("FAIL arst_round_rst got %b want 0", bus.round_rst); else passes++;
        checks++; if (bus.scores !== 6'd0) $display("FAIL arst_scores got %b want 000000", bus.scores); else passes++;
        checks++; if (bus.win_valid !== 1'b0 || bus.game_over !== 1'b0) $display("FAIL arst_flags got valid=%b go=%b want 0/0", bus.win_valid, bus.game_over); else passes++;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_simultaneous();
        test_hit_vs_new_game();
        test_game_over();
        test_hold();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
